// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, W16 twiddle ROM and scale/saturate helpers (FFT_STAGE2_ROUND_EN)
package fft_pkg;

  localparam int IN_W    = 14;
  localparam int OUT_W   = 15;
  localparam int TW_W    = 8;
  localparam int TW_FRAC = 6;
  // wide enough for (head - sample) * twiddle summed over two products
  localparam int PROD_W  = OUT_W + TW_W + 2;

  localparam int SAT_HI = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_LO = -(1 << (OUT_W - 1));

`ifdef FFT_STAGE2_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1 << (TW_FRAC - 1));
`endif

  function automatic logic signed [TW_W-1:0] tw_re(input logic [2:0] k);
    case (k)
      3'd0: return 8'sd64;
      3'd1: return 8'sd59;
      3'd2: return 8'sd45;
      3'd3: return 8'sd24;
      3'd4: return 8'sd0;
      3'd5: return -8'sd24;
      3'd6: return -8'sd45;
      default: return -8'sd59;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] tw_im(input logic [2:0] k);
    case (k)
      3'd0: return 8'sd0;
      3'd1: return -8'sd24;
      3'd2: return -8'sd45;
      3'd3: return -8'sd59;
      3'd4: return -8'sd64;
      3'd5: return -8'sd59;
      3'd6: return -8'sd45;
      default: return -8'sd24;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] v);
    if (v > $signed(PROD_W'(SAT_HI)))
      return OUT_W'(SAT_HI);
    else if (v < $signed(PROD_W'(SAT_LO)))
      return OUT_W'(SAT_LO);
    else
      return v[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] r;
`ifdef FFT_STAGE2_ROUND_EN
    r = (p + ROUND_BIAS) >>> TW_FRAC;
`else
    r = p >>> TW_FRAC;
`endif
    return sat_out(r);
  endfunction

endpackage

// File: rtl/fft_stage2_sr8.sv
// rtl/fft_stage2_sr8.sv - 8-deep complex feedback delay line with shift enable
module sr8
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [OUT_W-1:0] push_r,
  input  logic signed [OUT_W-1:0] push_i,
  output logic signed [OUT_W-1:0] head_r,
  output logic signed [OUT_W-1:0] head_i
);

  logic signed [OUT_W-1:0] line_r [8];
  logic signed [OUT_W-1:0] line_i [8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        line_r[i] <= '0;
        line_i[i] <= '0;
      end
    end else if (en) begin
      line_r[0] <= push_r;
      line_i[0] <= push_i;
      for (int i = 1; i < 8; i++) begin
        line_r[i] <= line_r[i-1];
        line_i[i] <= line_i[i-1];
      end
    end
  end

  assign head_r = line_r[7];
  assign head_i = line_i[7];

endmodule

// File: rtl/fft_stage2.sv
// rtl/fft_stage2.sv - R2SDF stage 2 (8-deep feedback, W16 twiddles); FFT_STAGE2_ROUND_EN selects rounding
module fft_stage2
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  data_in_r,
  input  logic signed [IN_W-1:0]  data_in_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] data_out_r,
  output logic signed [OUT_W-1:0] data_out_i
);

  logic                    v_q;
  logic signed [IN_W-1:0]  x_r_q, x_i_q;
  logic [3:0]              cnt;
  logic                    primed;
  logic signed [OUT_W-1:0] xs_r, xs_i;
  logic signed [OUT_W-1:0] head_r, head_i;
  logic signed [OUT_W-1:0] push_r, push_i;
  logic signed [OUT_W-1:0] out_r, out_i;
  logic signed [TW_W-1:0]  wr, wi;
  logic signed [PROD_W-1:0] sum_r, sum_i, diff_r, diff_i, prod_r, prod_i;

  assign xs_r = OUT_W'(x_r_q);
  assign xs_i = OUT_W'(x_i_q);

  sr8 u_sr8 (
    .clk    (clk),
    .rst    (rst),
    .en     (v_q),
    .push_r (push_r),
    .push_i (push_i),
    .head_r (head_r),
    .head_i (head_i)
  );

  // cnt[3] selects butterfly vs fill; cnt[2:0] is the twiddle index k
  always_comb begin
    wr     = tw_re(cnt[2:0]);
    wi     = tw_im(cnt[2:0]);
    sum_r  = PROD_W'(head_r) + PROD_W'(xs_r);
    sum_i  = PROD_W'(head_i) + PROD_W'(xs_i);
    diff_r = PROD_W'(head_r) - PROD_W'(xs_r);
    diff_i = PROD_W'(head_i) - PROD_W'(xs_i);
    prod_r = diff_r * PROD_W'(wr) - diff_i * PROD_W'(wi);
    prod_i = diff_r * PROD_W'(wi) + diff_i * PROD_W'(wr);
    out_r  = head_r;
    out_i  = head_i;
    push_r = xs_r;
    push_i = xs_i;
    if (cnt[3]) begin
      out_r  = sat_out(sum_r);
      out_i  = sat_out(sum_i);
      push_r = scale_sat(prod_r);
      push_i = scale_sat(prod_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= 1'b0;
      x_r_q      <= '0;
      x_i_q      <= '0;
      cnt        <= '0;
      primed     <= 1'b0;
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      v_q     <= valid_i;
      x_r_q   <= data_in_r;
      x_i_q   <= data_in_i;
      valid_o <= v_q && primed;
      if (v_q) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7)
          primed <= 1'b1;
        // outputs during the first fill carry nothing and must not disturb the held value
        if (primed) begin
          data_out_r <= out_r;
          data_out_i <= out_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_stage2.sv
// tb/tb_fft_stage2.sv - self-checking bench for fft_stage2 against a block-level FFT-stage model
module tb_fft_stage2;
  import fft_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_i;
  logic signed [IN_W-1:0]  data_in_r, data_in_i;
  logic                    valid_o;
  logic signed [OUT_W-1:0] data_out_r, data_out_i;

  fft_stage2 dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hist_r[$], hist_i[$];
  int exp_r[$], exp_i[$];
  int got_r[$], got_i[$];
  int last_r = 0, last_i = 0;
  int first_vo_cyc = -1;
  int ninth_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int m_tw_re(input int k);
    return $rtoi($floor(64.0 * $cos(2.0 * PI * k / 16.0) + 0.5));
  endfunction

  function automatic int m_tw_im(input int k);
    return $rtoi($floor(-64.0 * $sin(2.0 * PI * k / 16.0) + 0.5));
  endfunction

  function automatic int m_sat(input int v);
    if (v > 16383) return 16383;
    if (v < -16384) return -16384;
    return v;
  endfunction

  function automatic int m_scale(input longint p);
    real q;
`ifdef FFT_STAGE2_ROUND_EN
    q = $floor(p / 64.0 + 0.5);
`else
    q = $floor(p / 64.0);
`endif
    return m_sat($rtoi(q));
  endfunction

  // output for global sample g: sum of pair in second half, twiddled difference of previous block in first half
  function automatic void model_out(input int g);
    int n, k;
    longint dr, di, wr, wi;
    if (g < 8) return;
    n = g % 16;
    if (n >= 8) begin
      exp_r.push_back(m_sat(hist_r[g-8] + hist_r[g]));
      exp_i.push_back(m_sat(hist_i[g-8] + hist_i[g]));
    end else begin
      k  = n;
      dr = hist_r[g-16] - hist_r[g-8];
      di = hist_i[g-16] - hist_i[g-8];
      wr = m_tw_re(k);
      wi = m_tw_im(k);
      exp_r.push_back(m_scale(dr * wr - di * wi));
      exp_i.push_back(m_scale(dr * wi + di * wr));
    end
  endfunction

  function automatic int got_at(input bit im, input int idx);
    if (idx < 0 || idx >= got_r.size()) return -99999;
    return im ? got_i[idx] : got_r[idx];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid_o", int'(valid_o), 0);
      chk("rst_out_r", int'(data_out_r), 0);
      chk("rst_out_i", int'(data_out_i), 0);
      last_r = 0;
      last_i = 0;
    end else if (valid_o) begin
      if (exp_r.size() == 0) begin
        chk("spurious_valid_o", 1, 0);
      end else begin
        chk("out_r", int'(data_out_r), exp_r.pop_front());
        chk("out_i", int'(data_out_i), exp_i.pop_front());
      end
      got_r.push_back(int'(data_out_r));
      got_i.push_back(int'(data_out_i));
      last_r = int'(data_out_r);
      last_i = int'(data_out_i);
      if (first_vo_cyc < 0) first_vo_cyc = cyc;
    end else begin
      chk("hold_r", int'(data_out_r), last_r);
      chk("hold_i", int'(data_out_i), last_i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      valid_i   = c[0];
      data_in_r = IN_W'(c * 311 + 7);
      data_in_i = IN_W'(-c * 97);
      tick();
    end
    valid_i = 1'b0;
    hist_r.delete(); hist_i.delete();
    exp_r.delete(); exp_i.delete();
    first_vo_cyc = -1;
    ninth_cyc    = -1;
    rst = 1'b1;
    tick();
  endtask

  task automatic send(input int r, input int i, input int gapmax);
    int gap;
    valid_i   = 1'b1;
    data_in_r = IN_W'(r);
    data_in_i = IN_W'(i);
    if (hist_r.size() == 8) ninth_cyc = cyc;
    hist_r.push_back(r);
    hist_i.push_back(i);
    model_out(hist_r.size() - 1);
    tick();
    valid_i   = 1'b0;
    data_in_r = IN_W'(777);
    data_in_i = IN_W'(-555);
    gap = (gapmax == 0) ? 0 : int'($urandom_range(1, gapmax));
    repeat (gap) tick();
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    chk(name, exp_r.size(), 0);
  endtask

  task automatic run_dc(input int gapmax, output int base);
    do_reset();
    base = got_r.size();
    for (int n = 0; n < 16; n++) send(100, 0, gapmax);
    for (int n = 0; n < 16; n++) send(0, 0, gapmax);
    drain("dc_drain");
    chk("dc_count", got_r.size() - base, 24);
    chk("dc_first_valid_o_latency", first_vo_cyc - ninth_cyc, 2);
    for (int j = 0; j < 8; j++) begin
      chk("dc_sum_r", got_at(0, base + j), 200);
      chk("dc_sum_i", got_at(1, base + j), 0);
      chk("dc_diff_r", got_at(0, base + 8 + j), 0);
      chk("dc_diff_i", got_at(1, base + 8 + j), 0);
    end
  endtask

  task automatic run_tw(input int gapmax, output int base);
    do_reset();
    base = got_r.size();
    for (int n = 0; n < 32; n++) send((n == 3) ? 100 : 0, 0, gapmax);
    drain("tw_drain");
    chk("tw_count", got_r.size() - base, 24);
    chk("tw_sum3_r", got_at(0, base + 3), 100);
    chk("tw_sum3_i", got_at(1, base + 3), 0);
`ifdef FFT_STAGE2_ROUND_EN
    chk("tw_diff3_r", got_at(0, base + 11), 38);
    chk("tw_diff3_i", got_at(1, base + 11), -92);
`else
    chk("tw_diff3_r", got_at(0, base + 11), 37);
    chk("tw_diff3_i", got_at(1, base + 11), -93);
`endif
  endtask

  initial begin
    int dc_ref, tw_ref, dc_gap, tw_gap, base;
    rst = 1'b0;
    valid_i = 1'b0;
    data_in_r = '0;
    data_in_i = '0;

    chk("model_tw1_r", m_tw_re(1), 59);
    chk("model_tw3_i", m_tw_im(3), -59);
    chk("model_tw6_r", m_tw_re(6), -45);

    do_reset();
    repeat (3) tick();
    chk("post_reset_quiet", got_r.size(), 0);

    run_dc(0, dc_ref);
    run_tw(0, tw_ref);

    do_reset();
    base = got_r.size();
    for (int n = 0; n < 32; n++) begin
      if (n == 2) send(8191, 8191, 0);
      else if (n == 10) send(-8192, -8192, 0);
      else send(0, 0, 0);
    end
    drain("sat_drain");
    chk("sat_sum_r", got_at(0, base + 2), -1);
    chk("sat_sum_i", got_at(1, base + 2), -1);
    chk("sat_diff_r", got_at(0, base + 10), 16383);
    chk("sat_diff_i", got_at(1, base + 10), 0);

    run_dc(3, dc_gap);
    run_tw(3, tw_gap);
    for (int j = 0; j < 24; j++) begin
      chk("gap_dc_r", got_at(0, dc_gap + j), got_at(0, dc_ref + j));
      chk("gap_tw_r", got_at(0, tw_gap + j), got_at(0, tw_ref + j));
      chk("gap_tw_i", got_at(1, tw_gap + j), got_at(1, tw_ref + j));
    end

    do_reset();
    for (int n = 0; n < 12; n++) send(50, -20, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid_o", int'(valid_o), 0);
    chk("midrst_out_r", int'(data_out_r), 0);
    chk("midrst_out_i", int'(data_out_i), 0);
    hist_r.delete(); hist_i.delete();
    exp_r.delete(); exp_i.delete();
    first_vo_cyc = -1;
    ninth_cyc    = -1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    base = got_r.size();
    for (int n = 0; n < 32; n++) send(n * 37 - 500, 300 - n * 11, 0);
    drain("ramp_drain");
    chk("ramp_count", got_r.size() - base, 24);
    chk("ramp_first_valid_o_latency", first_vo_cyc - ninth_cyc, 2);
    chk("ramp_sum0_r", got_at(0, base), -1000 + 8 * 37);
    chk("ramp_sum0_i", got_at(1, base), 600 - 8 * 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_stage2.md
# fft_stage2

Second radix-2 single-path delay-feedback (R2SDF) stage of the 32-point FFT pipeline. It consumes the 14-bit complex stream produced by stage 1 (16-deep feedback) and performs the 8-deep-feedback butterfly. It applies W16 twiddles to the difference branch and emits a 15-bit complex stream to stage 3.

## Interface
- IN_W, 14: input word width per component (signed)
- OUT_W, 15: output word width per component (signed)
- TW_W, 8: twiddle width (signed Q1.6)
- TW_FRAC, 6: twiddle fractional bits
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  data_in_* carries a sample this cycle
- data_in_r / data_in_i  in  IN_W  stage-1 output sample
- valid_o  out  1  data_out_* carries a valid sample this cycle
- data_out_r / data_out_i  out  OUT_W  stage-2 output sample

## Operation
- Register valid_i and data_in_* on every clk before any logic.
- Sample counter cnt[3:0] advances only on a registered valid sample and wraps 15→0.
- Delay line is 8 entries of OUT_W complex values. It shifts only on a registered valid sample.
- Fill phase (cnt[3]=0):
  - delay-line input = sign-extended sample
  - output = delay-line head, which holds the twiddled differences from the previous block
- Butterfly phase (cnt[3]=1), with k = cnt[2:0]:
  - output = head + sample
  - delay-line input = (head − sample) × W16^k
- Twiddle ROM, (real, imag) for k = 0..7:
  - (64,0), (59,−24), (45,−45), (24,−59), (0,−64), (−24,−59), (−45,−45), (−59,−24)
- Complex multiply: re = ac − bd, im = ad + bc, at full precision.
- Scale each product component by arithmetic right shift of TW_FRAC bits, then saturate to OUT_W (±16383 / −16384).
- Sums: both operands are OUT_W, so the sum never overflows for IN_W inputs. Still saturate to OUT_W.
- Priming: a primed flag sets after the first 8 valid samples following reset. valid_o pulses for every valid sample once primed.
- Gap on valid_i: cnt, the delay line and the outputs hold; valid_o = 0.
- Reset, including mid-frame:
  - cnt = 0, primed = 0
  - delay line and input registers = 0
  - valid_o = 0, data_out_* = 0

## Timing
- Sample presented at edge N is captured at N; its result is registered at edge N+1 and visible after N+1. Pipeline latency is 2 clocks.
- Stream latency: the output for pair (k, k+8) sum appears on the (k+9)th valid input; the twiddled difference appears 8 valid samples later.
- Continuous valid_i gives a continuous valid_o once primed (throughput 1 sample/clk).
- data_out_* holds its last value while valid_o = 0.

## Configuration
- FFT_STAGE2_ROUND_EN defined: add 2^(TW_FRAC−1) to each product component before the shift (round-half-up).
- Undefined: plain arithmetic shift (floor truncation).
- Saturation is present in both builds.

## Structure
- Shared package fft_pkg holds:
  - width constants IN_W, OUT_W, TW_W, TW_FRAC
  - the W16 twiddle ROM constants
  - the complex saturate/scale helper function
- Sub-module sr8: 8-deep complex shift register with enable, async active-low reset to 0.
- Counter, twiddle select, butterfly, multiplier and output registers live in fft_stage2.

## Test plan
- Reset: hold rst=0 with valid_i toggling → valid_o=0 and data_out_*=0 throughout; no state change on release.
- DC: 16 continuous samples of (100,0) → outputs 9–16 are (200,0), then 8 outputs of (0,0); valid_o rises 2 clocks after the 9th input.
- Twiddle/rounding: block with x[3]=(100,0), all others 0:
  - butterfly output index 3 = (100,0)
  - next fill output index 3 = (38,−92) with FFT_STAGE2_ROUND_EN
  - (37,−93) without it
- Saturation: x[2]=(8191,8191), x[10]=(−8192,−8192) → difference output for k=2 = (16383,0); sum output = (−1,−1).
- Valid gaps: the DC and twiddle streams with 1–3 idle cycles between samples → identical output sequence; valid_o low in gaps; data_out_* held.
- Mid-frame reset: assert rst at cnt=11 → all outputs 0 immediately. A fresh 16-sample block then re-primes, and the first valid_o appears on its 9th sample.
